// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode-side
// instruction handshake and the branch-resolution inputs sampled on acceptance.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    // Handshakes: imem_req/imem_ack completes a read in any cycle where both are
    // high (same-cycle ack allowed); instr_valid/instr_ready retires the held
    // instruction in any cycle where both are high. A raised request or valid is
    // held, with its payload stable, until the matching ack or ready arrives.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus4;
    logic [1:0]        branch;
    logic              branch_cond;
    logic [ADDR_W-1:0] branch_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc_out, pc_plus4,
        input  imem_ack, imem_rdata, instr_ready, branch, branch_cond, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out, pc_plus4,
        output imem_ack, imem_rdata, instr_ready, branch, branch_cond, branch_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// KGP-RISC instruction fetch: holds the PC, reads one word per request, presents
// it to decode and resolves the next PC from the decoder's branch code on accept.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus,
    output logic                misalign_err,
    output logic [31:0]         retired_count,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [31:0]       instr_q;
    logic              misalign_q;
    logic [31:0]       retired_q;

    logic              req;
    logic              valid;
    logic              capture;
    logic              accept;
    logic              taken;
    logic [ADDR_W-1:0] next_pc;

    always_comb begin
        state_n = state_q;
        req     = 1'b0;
        valid   = 1'b0;
        capture = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_RESET: state_n = S_REQ;
            S_REQ: begin
                req = 1'b1;
                if (bus.imem_ack) begin
                    capture = 1'b1;
                    state_n = S_VALID;
                end
            end
            S_VALID: begin
                valid = 1'b1;
                if (bus.instr_ready) begin
                    accept  = 1'b1;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_RESET;
        endcase
    end

    // Branch inputs only matter in the accept cycle; the aligned target is used
    // even when the low bits are set, and the error flag records the event.
    always_comb begin
        taken   = (bus.branch == 2'b10) || (bus.branch == 2'b11) ||
                  ((bus.branch == 2'b01) && bus.branch_cond);
        next_pc = taken ? {bus.branch_target[ADDR_W-1:2], 2'b00}
                        : pc_q + ADDR_W'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_PC;
            pc_out_q   <= RESET_PC;
            instr_q    <= '0;
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q <= state_n;
            if (capture) begin
                instr_q  <= bus.imem_rdata;
                pc_out_q <= pc_q;
            end
            if (accept) begin
                pc_q      <= next_pc;
                retired_q <= retired_q + 32'd1;
                if (taken && (bus.branch_target[1:0] != 2'b00))
                    misalign_q <= 1'b1;
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.pc_out      = pc_out_q;
    assign bus.pc_plus4    = pc_out_q + ADDR_W'(4);
    assign misalign_err    = misalign_q;
    assign retired_count   = retired_q;
    assign fsm_state       = state_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the KGP-RISC datapath, directly upstream of the main control decoder. Holds the PC, fetches one 32-bit instruction per transaction over a request/acknowledge instruction-memory port, and presents the held instruction and its opcode field to decode. When decode accepts an instruction, the unit computes the next PC from the decoder's 2-bit branch code and the branch condition.

## Interface
- ADDR_W, 32, PC and memory address width
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  instruction-memory read request
- imem_addr  out  ADDR_W  read address; equals the current PC
- imem_ack  in  1  read data valid; may be high in the same cycle as imem_req
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ack
- instr_valid  out  1  instr/opcode/pc_out hold a fetched instruction
- instr_ready  in  1  decode accepts the instruction this cycle
- instr  out  32  held instruction word
- opcode  out  6  instr[31:26], feeds the main control decoder
- pc_out  out  ADDR_W  address of the held instruction
- pc_plus4  out  ADDR_W  pc_out + 4, link value for branch code 11
- branch  in  2  decoder branch code: 00 sequential, 01 conditional, 10 jump, 11 jump-and-link
- branch_cond  in  1  condition result for code 01
- branch_target  in  ADDR_W  redirect address for codes 01/10/11
- misalign_err  out  1  sticky; set when a taken target has bits [1:0] != 0
- retired_count  out  32  number of accepted instructions

## Operation
- FSM states: S_RESET, S_REQ, S_VALID.
- S_RESET: entered on rst; imem_req=0, instr_valid=0. Next cycle → S_REQ.
- S_REQ: imem_req=1, imem_addr=pc. If imem_ack, capture imem_rdata into instr and go to S_VALID. Otherwise hold the request with a stable address.
- S_VALID: instr_valid=1. instr, opcode, pc_out and pc_plus4 are held stable until acceptance. On instr_ready, update pc and retired_count, then go to S_REQ.
- Taken rule: code 01 && branch_cond, or code 10, or code 11. Code 01 with !branch_cond, and code 00, are not taken.
- Next PC: if taken, {branch_target[ADDR_W-1:2], 2'b00}; otherwise pc + 4.
- A taken target with nonzero bits [1:0] sets misalign_err; the fetch still proceeds from the aligned address.
- branch, branch_cond and branch_target are sampled only on cycles where instr_valid && instr_ready; all other values are ignored.
- pc + 4 wraps modulo 2^ADDR_W (0xFFFFFFFC → 0x00000000); no error is raised.
- retired_count wraps modulo 2^32.
- imem_rdata is ignored while imem_ack is low. imem_ack is ignored outside S_REQ.

## Timing
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, pc_out=RESET_PC, pc_plus4=RESET_PC+4, misalign_err=0, retired_count=0.
- First cycle after rst deasserts: state is S_RESET. imem_req rises one cycle later, i.e. the 2nd cycle after deassertion.
- Fetch latency: instr_valid rises the cycle after the ack cycle. With zero-wait memory, imem_req and imem_ack are high in the same cycle, and instr_valid follows one cycle later.
- Throughput: at best one instruction per 2 cycles (S_REQ → S_VALID).
- Redirect: the new PC appears on imem_addr in the cycle immediately after acceptance; no wrong-path fetch occurs.
- Backpressure: with instr_valid high and instr_ready low, all outputs are held indefinitely.
- Reset mid-operation: rst overrides all state, including an outstanding request or a held instruction. The instruction memory shares rst, so no stale ack may arrive after reset.
- rst and instr_ready asserted in the same cycle: rst wins and the instruction is not retired.

## Test plan
- Reset then run: RESET_PC=0 and zero-wait memory returning 0x04000000 (opcode 000001) → imem_addr sequence 0,4,8; opcode=6'b000001; retired_count=3 after three accepts.
- Conditional branch: at pc=0x10, branch=01 and target=0x40, with cond=1 and then cond=0 → next imem_addr 0x40, and on the second run 0x14.
- Jump-and-link: at pc=0x20, branch=11 and target=0x100 → pc_plus4=0x24 during acceptance; next imem_addr=0x100.
- Backpressure and wait states: ack delayed 3 cycles and ready held low 4 cycles → req and addr stable during the wait; instr/pc_out stable while valid; no retire.
- Boundaries: pc=0xFFFFFFFC sequential → next addr 0x0. A taken target 0x42 → addr 0x40 and misalign_err=1, sticky until rst.
- Reset mid-wait: rst asserted while in S_REQ with ack low → next cycle imem_req=0 and instr_valid=0; the fetch restarts at RESET_PC.
